truth_table_sweeper: RTL and testbench
======================================

// Module: truth_table_sweeper
// PURPOSE
//  Downstream characterisation stage for a 3-input combinational logic-gate module (in1, in2, in3 -> out).
//  - On start, steps the gate inputs through all 2^N_IN input vectors, from 000 to 111.
//  - After each input change, waits SETTLE_CYCLES cycles, then samples the gate output.
//  - Assembles the samples into a truth-table word and compares it against EXPECTED.
// PARAMETERS
//  N_IN           3      number of gate inputs; the table is 2^N_IN bits wide
//  SETTLE_CYCLES  16     cycles each input vector is held before sampling; >=1, and >=3 when voting is enabled
//  EXPECTED       8'hE9  reference truth table; bit i = required output for input vector i
// PORTS
//  clk        input   1         single clock, rising edge
//  rst        input   1         synchronous reset, active high
//  start      input   1         request a sweep; sampled only in IDLE
//  abort      input   1         cancel an in-progress sweep
//  drive_in   output  N_IN      input vector to the gate; bit N_IN-1 = in1 (MSB), bit 0 = in3
//  dut_out    input   1         gate output being characterised
//  busy       output  1         high while in SETTLE or DONE
//  done       output  1         1-cycle pulse; sweep complete
//  table_out  output  2^N_IN    captured table; bit i = output sampled for input vector i
//  match      output  1         table_out == EXPECTED; updated on done
// BEHAVIOUR
//  Reset values: drive_in=0, busy=0, done=0, table_out=0, match=0, state=IDLE, idx=0, cnt=0.
//  FSM states: IDLE, SETTLE, DONE.
//  - IDLE: on start=1, clear table_out and match, set idx=0, drive_in=0, cnt=0, go to SETTLE.
//  - SETTLE: cnt increments every cycle.
//    - On the cycle where cnt==SETTLE_CYCLES-1, write the sample into table_out[idx].
//    - Then, if idx==2^N_IN-1, go to DONE.
//    - Otherwise set idx=idx+1, drive_in=idx+1, cnt=0.
//  - DONE: done=1 for this one cycle, match <= (table_out==EXPECTED), return to IDLE.
//  Latency: done is asserted 2^N_IN*SETTLE_CYCLES+1 cycles after the start edge. With defaults this is 129.
//  drive_in changes only when idx advances, so it is glitch-free and registered.
//  Sweep order is fixed ascending. idx does not wrap; sweep ends after the last vector.
//  start while busy is ignored. start in the DONE cycle is also ignored; a new sweep begins one cycle later at the earliest.
//  abort has priority over everything except rst. It takes effect from SETTLE or DONE:
//    state=IDLE, drive_in=0, done stays 0, match=0, table_out keeps its partial contents.
//  If abort and start are both high in IDLE, abort wins and no sweep starts.
//  rst mid-sweep: all registers return to their reset values on the next edge; no done pulse.
//  cnt width is $clog2(SETTLE_CYCLES)+1. idx width is N_IN+1, so the final compare does not overflow.
// CONFIGURATION
//  SWEEP_VOTE_EN defined:
//    - dut_out is captured on the last 3 settle cycles (cnt = SETTLE_CYCLES-3 .. SETTLE_CYCLES-1).
//    - The stored bit is the majority of the three samples.
//    - An elaboration check fails if SETTLE_CYCLES<3.
//  SWEEP_VOTE_EN undefined: a single sample of dut_out is taken at cnt==SETTLE_CYCLES-1.
//  Latency is identical in both builds.
// STRUCTURE
//  Package sweep_pkg holds:
//    - sweep_state_t enum {IDLE, SETTLE, DONE}
//    - localparam function for the vector count (2^N_IN)
//    - the majority-of-3 function
//  Sub-module sweep_settle_timer:
//    - inputs: clear, enable
//    - outputs: last (cnt==SETTLE_CYCLES-1) and, under SWEEP_VOTE_EN, a vote window flag
//  The top-level module contains the FSM, idx/drive_in registers, table capture and compare.
// TESTING
//  1. Behavioural 0xE9 gate model on drive_in/dut_out, start pulse -> done at cycle 129, table_out=8'hE9, match=1.
//  2. Gate model forced to constant 1 -> table_out=8'hFF, match=0; drive_in steps 0..7, 16 cycles each.
//  3. abort at cycle 40 -> busy=0 next cycle, no done, drive_in=0, table_out[1:0]=2'b01 for the 0xE9 model.
//  4. rst asserted mid-sweep at vector 5 -> all outputs 0 next cycle; a new start then gives a full 129-cycle sweep.
//  5. start held high continuously -> back-to-back sweeps, with done pulses 130 cycles apart.
//  6. SWEEP_VOTE_EN, dut_out glitched low for 1 cycle inside the vote window on vector 7 -> table_out[7]=1, match=1.

Source files
------------

// File: rtl/sweep_pkg.sv
// Shared types and helpers for the truth-table sweeper.
// Build option: SWEEP_VOTE_EN enables majority-of-3 sampling.
package sweep_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    DONE
  } sweep_state_t;

  function automatic int vec_count(int n);
    return 1 << n;
  endfunction

  function automatic logic maj3(
    logic a,
    logic b,
    logic c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Control, gate-drive and result bundle of the sweeper.
// Build option: SWEEP_VOTE_EN (no effect on this bundle).
interface truth_table_sweeper_if #(
  parameter int N_IN = 3
);
  import sweep_pkg::*;

  logic                       start;
  logic                       abort;
  logic [N_IN-1:0]            drive_in;
  logic                       dut_out;
  logic                       busy;
  logic                       done;
  logic [vec_count(N_IN)-1:0] table_out;
  logic                       match;

  modport master (
    output start, abort, dut_out,
    input  drive_in, busy, done,
    input  table_out, match
  );

  modport slave (
    input  start, abort, dut_out,
    output drive_in, busy, done,
    output table_out, match
  );
endinterface

// File: rtl/sweep_settle_timer.sv
// Per-vector settle counter with last-cycle and vote-window flags.
// Build option: SWEEP_VOTE_EN adds the vote window output.
module sweep_settle_timer #(
  parameter int SETTLE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
`ifdef SWEEP_VOTE_EN
  output logic win,
`endif
  output logic last
);
  localparam int CW = $clog2(SETTLE_CYCLES) + 1;

  logic [CW-1:0] cnt;

  // count settle cycles; cleared between vectors and outside a sweep
  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (clear)
      cnt <= '0;
    else if (enable)
      cnt <= cnt + CW'(1);
  end

  assign last = (cnt == CW'(SETTLE_CYCLES - 1));

`ifdef SWEEP_VOTE_EN
  assign win = (cnt >= CW'(SETTLE_CYCLES - 3));
`endif

endmodule

// File: rtl/truth_table_sweeper.sv
// Steps a gate through all input vectors and captures its truth table.
// Build option: SWEEP_VOTE_EN stores a majority of 3 late samples.
module truth_table_sweeper
  import sweep_pkg::*;
#(
  parameter int                    N_IN          = 3,
  parameter int                    SETTLE_CYCLES = 16,
  parameter logic [(1<<N_IN)-1:0]  EXPECTED      = 8'hE9
) (
  input logic                  clk,
  input logic                  rst,
  truth_table_sweeper_if.slave bus
);
  localparam int NV = vec_count(N_IN);
  localparam int IW = N_IN + 1;

`ifdef SWEEP_VOTE_EN
  if (SETTLE_CYCLES < 3) begin : g_vote_chk
    $error("SETTLE_CYCLES must be >= 3 when voting");
  end
`else
  if (SETTLE_CYCLES < 1) begin : g_settle_chk
    $error("SETTLE_CYCLES must be >= 1");
  end
`endif

  sweep_state_t    state, nxt;
  logic [IW-1:0]   idx;
  logic [N_IN-1:0] drive_q;
  logic [NV-1:0]   table_q;
  logic            match_q;
  logic            done_q;
  logic            last;
  logic            clear;
  logic            smp;
  logic            fin;

  assign clear = (state != SETTLE) | last | bus.abort;
  assign fin   = (idx == IW'(NV - 1));

`ifdef SWEEP_VOTE_EN
  logic       win;
  logic [1:0] vs;

  sweep_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_tmr (
    .clk    (clk),
    .rst    (rst),
    .clear  (clear),
    .enable (state == SETTLE),
    .win    (win),
    .last   (last)
  );

  // shift in the early vote-window samples ahead of the last one
  always_ff @(posedge clk) begin
    if (rst)
      vs <= '0;
    else if (win && !last)
      vs <= {vs[0], bus.dut_out};
  end

  assign smp = maj3(vs[1], vs[0], bus.dut_out);
`else
  sweep_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_tmr (
    .clk    (clk),
    .rst    (rst),
    .clear  (clear),
    .enable (state == SETTLE),
    .last   (last)
  );

  assign smp = bus.dut_out;
`endif

  // state register
  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= nxt;
  end

  // next-state decode; abort beats start and sweep progress
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:
        if (bus.start && !bus.abort)
          nxt = SETTLE;
      SETTLE:
        if (bus.abort)
          nxt = IDLE;
        else if (last && fin)
          nxt = DONE;
      DONE:
        nxt = IDLE;
      default:
        nxt = IDLE;
    endcase
  end

  // state-derived outputs
  always_comb begin
    bus.busy = (state != IDLE);
  end

  // vector index, gate drive, table capture, compare and done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      idx     <= '0;
      drive_q <= '0;
      table_q <= '0;
      match_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start && !bus.abort) begin
            idx     <= '0;
            drive_q <= '0;
            table_q <= '0;
            match_q <= 1'b0;
          end
        end
        SETTLE: begin
          if (bus.abort) begin
            idx     <= '0;
            drive_q <= '0;
            match_q <= 1'b0;
          end else if (last) begin
            table_q[idx[N_IN-1:0]] <= smp;
            if (!fin) begin
              idx     <= idx + IW'(1);
              drive_q <= N_IN'(idx + IW'(1));
            end
          end
        end
        DONE: begin
          if (bus.abort) begin
            idx     <= '0;
            drive_q <= '0;
            match_q <= 1'b0;
          end else begin
            match_q <= (table_q == EXPECTED);
            done_q  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.drive_in  = drive_q;
  assign bus.table_out = table_q;
  assign bus.match     = match_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench for truth_table_sweeper with a behavioural gate.
// Build option: SWEEP_VOTE_EN changes the glitch scenario expectation.
module tb_truth_table_sweeper;
  import sweep_pkg::*;

  typedef struct {
    logic [7:0] tt;
    logic       m;
    int         at;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   ndone = 0;
  logic [7:0] model_tt = 8'hE9;
  logic glitch = 1'b0;
  exp_t sb[$];

  truth_table_sweeper_if #(.N_IN(3)) bus();

  truth_table_sweeper #(
    .N_IN          (3),
    .SETTLE_CYCLES (16),
    .EXPECTED      (8'hE9)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb bus.dut_out = model_tt[bus.drive_in] & ~glitch;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // monitor: every done pulse is matched against the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (bus.done === 1'b1) begin
      ndone++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done at cyc %0d want none", cyc);
      end else begin
        e = sb.pop_front();
        chk("table_out", 32'(bus.table_out), 32'(e.tt));
        chk("match", 32'(bus.match), 32'(e.m));
        chk("done_cycle", cyc, e.at);
      end
    end
  end

  task automatic wait_cyc(int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic pulse_start(output int s);
    @(negedge clk);
    bus.start = 1'b1;
    s = cyc + 1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic push(logic [7:0] tt, logic m, int at);
    exp_t e;
    e.tt = tt;
    e.m  = m;
    e.at = at;
    sb.push_back(e);
  endtask

  task automatic wait_empty(string nm, int lim);
    int n = 0;
    while (sb.size() > 0 && n < lim) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (sb.size() > 0) begin
      bad++;
      $display("FAIL %s: got %0d pending want 0 (timeout)", nm, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    int s;
    int nd;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_drive_in", 32'(bus.drive_in), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_table", 32'(bus.table_out), 0);
    chk("rst_match", 32'(bus.match), 0);
    rst = 1'b0;

    // nominal 0xE9 gate
    model_tt = 8'hE9;
    pulse_start(s);
    push(8'hE9, 1'b1, s + 129);
    chk("busy_after_start", 32'(bus.busy), 1);
    wait_empty("sweep_e9", 200);

    // stuck-at-1 gate, drive_in stepping
    model_tt = 8'hFF;
    pulse_start(s);
    push(8'hFF, 1'b0, s + 129);
    for (int k = 0; k < 8; k++) begin
      wait_cyc(s + 16 * k + 8);
      chk($sformatf("drive_step%0d", k), 32'(bus.drive_in), k);
    end
    wait_empty("sweep_ff", 200);

    // abort partway through vector 2
    model_tt = 8'hE9;
    pulse_start(s);
    wait_cyc(s + 39);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_drive_in", 32'(bus.drive_in), 0);
    chk("abort_table", 32'(bus.table_out), 32'h01);
    chk("abort_match", 32'(bus.match), 0);
    nd = ndone;
    repeat (150) @(negedge clk);
    chk("abort_no_done", ndone, nd);

    // abort and start together in IDLE
    bus.abort = 1'b1;
    pulse_start(s);
    bus.abort = 1'b0;
    chk("abort_start_idle", 32'(bus.busy), 0);

    // reset during vector 5, then a full sweep
    pulse_start(s);
    wait_cyc(s + 84);
    chk("pre_rst_drive", 32'(bus.drive_in), 5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_drive", 32'(bus.drive_in), 0);
    chk("mid_rst_busy", 32'(bus.busy), 0);
    chk("mid_rst_done", 32'(bus.done), 0);
    chk("mid_rst_table", 32'(bus.table_out), 0);
    chk("mid_rst_match", 32'(bus.match), 0);
    pulse_start(s);
    push(8'hE9, 1'b1, s + 129);
    wait_empty("sweep_after_rst", 200);

    // start held high: back-to-back sweeps 130 cycles apart
    @(negedge clk);
    bus.start = 1'b1;
    s = cyc + 1;
    push(8'hE9, 1'b1, s + 129);
    push(8'hE9, 1'b1, s + 259);
    wait_cyc(s + 200);
    bus.start = 1'b0;
    wait_empty("back_to_back", 200);

    // one-cycle low glitch on vector 7
    pulse_start(s);
`ifdef SWEEP_VOTE_EN
    push(8'hE9, 1'b1, s + 129);
    wait_cyc(s + 126);
`else
    push(8'h69, 1'b0, s + 129);
    wait_cyc(s + 127);
`endif
    glitch = 1'b1;
    @(negedge clk);
    glitch = 1'b0;
    wait_empty("glitch_v7", 200);

    repeat (5) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
